// File: rtl/serial_adder32.sv
// Digit-serial adder: Sum = A + B + Cin computed DIGIT bits per clock over WIDTH/DIGIT cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW    = DIGIT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               accept_c;
    logic               last_c;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT-1:0]   dsum;
    logic               dcarry;

    // One digit of the addition per cycle
    assign {dcarry, dsum} = DW'(a_sh[DIGIT-1:0]) + DW'(b_sh[DIGIT-1:0]) + DW'(carry);

    // Result fills from the MSB side so the last digit lands in the top slot
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_nxt = dsum;
        end else begin : g_multi
            assign res_nxt = {dsum, res[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN);
            done  <= (next_state == DONE);
        end
    end

    // Next-state and handshake decode
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(N - 1)) begin
                    last_c     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits retained for the overflow decision at completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            if (accept_c) begin
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
            end
            if (last_c) begin
                Ovf <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
            end
        end
    end
`endif

    // Operand shift registers, running carry and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (accept_c) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            res   <= res_nxt;
            carry <= dcarry;
            cnt   <= cnt + CNT_W'(1);
            if (last_c) begin
                Sum  <= res_nxt;
                Cout <= dcarry;
            end
        end
    end

endmodule
